// File: rtl/din_debounce.sv
// Two-flop (or deeper) synchroniser followed by a STABLE/CHECK debounce FSM.
// Optional rejected-glitch counter enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module din_debounce #(
    parameter int   SYNC_STAGES  = 2,
    parameter int   DEBOUNCE_CYC = 16,
    parameter logic RST_VAL      = 1'b0,
    parameter int   GLITCH_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    output logic                dout,
    output logic                dout_chg,
    output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_CHECK  = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_out;
    logic [0:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_dout;
    logic                   r_dout_chg;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_STABLE;
            r_cnt      <= '0;
            r_dout     <= RST_VAL;
            r_dout_chg <= 1'b0;
        end else begin
            r_dout_chg <= 1'b0;
            case (r_state)
                ST_STABLE: begin
                    r_cnt <= '0;
                    if (w_sync_out != r_dout) begin
                        if (DEBOUNCE_CYC == 1) begin
                            // Single-cycle debounce: hold off one cycle after a flip so pulses never abut.
                            if (!r_dout_chg) begin
                                r_dout     <= w_sync_out;
                                r_dout_chg <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_CHECK;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_sync_out != r_dout) begin
                        if (r_cnt >= CNT_LAST) begin
                            r_dout     <= w_sync_out;
                            r_dout_chg <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ST_STABLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_STABLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_STABLE;
                end
            endcase
        end
    end

    assign dout     = r_dout;
    assign dout_chg = r_dout_chg;
    assign busy     = (r_state == ST_CHECK);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                w_glitch;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    // A glitch is a CHECK that ends because the input fell back to the current level.
    assign w_glitch = (r_state == ST_CHECK) && (w_sync_out == r_dout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && !(&r_glitch_cnt)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_din_debounce.sv
// Directed and randomized bench for din_debounce with a cycle-level reference model.
module tb_din_debounce;

    localparam int   SS = 2;
    localparam int   DC = 4;
    localparam int   GW = 2;
    localparam logic RV = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dout;
    logic dout_chg;
    logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GW-1:0] glitch_cnt;
`endif

    din_debounce #(
        .SYNC_STAGES (SS),
        .DEBOUNCE_CYC(DC),
        .RST_VAL     (RV),
        .GLITCH_W    (GW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dout      (dout),
        .dout_chg  (dout_chg),
        .busy      (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: din seen through an SS-deep delay line; dout follows once the
    // delayed input has disagreed with it for DC consecutive edges.
    logic m_line[$];
    logic m_dout;
    logic m_chg;
    int   m_run;
    int   m_glitch;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic seen;
        if (rst) begin
            m_line.delete();
            for (int i = 0; i < SS; i++) m_line.push_back(RV);
            m_dout   = RV;
            m_chg    = 1'b0;
            m_run    = 0;
            m_glitch = 0;
        end else begin
            seen = m_line.pop_front();
            m_line.push_back(din);
            m_chg = 1'b0;
            if (seen != m_dout) begin
                m_run = m_run + 1;
                if (m_run == DC) begin
                    m_dout = seen;
                    m_chg  = 1'b1;
                    m_run  = 0;
                end
            end else begin
                if (m_run > 0 && m_glitch < (1 << GW) - 1) m_glitch = m_glitch + 1;
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic d, input logic r);
        din = d;
        rst = r;
        @(posedge clk);
        model_edge();
        #1;
        check("m_dout", dout, m_dout);
        check("m_chg", dout_chg, m_chg);
        check("m_busy", busy, m_run > 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("m_glitch", glitch_cnt, m_glitch);
`endif
    endtask

    initial begin
        int hold;
        logic d;

        // T1: reset held with din high
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1);
            check("t1_dout", dout, 1'b0);
            check("t1_chg", dout_chg, 1'b0);
            check("t1_busy", busy, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check("t1_glitch", glitch_cnt, 0);
`endif
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);

        // T2: clean rise
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0);
            check("t2_dout", dout, k >= 6);
            check("t2_chg", dout_chg, k == 6);
            check("t2_busy", busy, (k >= 3) && (k <= 5));
        end

        // T4: clean fall
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0);
            check("t4_dout", dout, k < 6);
            check("t4_chg", dout_chg, k == 6);
        end

        // T3: bounce then settle high
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0);
            check("t3_dout", dout, k >= 6);
            check("t3_chg", dout_chg, k == 6);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("t3_glitch", glitch_cnt, 1);
`endif

        // T5: reset in the middle of CHECK
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
        check("t5_pre", dout, 1'b0);
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b0);
        check("t5_busy_pre", busy, 1'b1);
        step(1'b1, 1'b1);
        check("t5_rst_dout", dout, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0);
            check("t5_dout", dout, k >= 6);
            check("t5_chg", dout_chg, k == 6);
        end

        // T6: repeated single-cycle glitches
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int g = 1; g <= 5; g++) begin
            step(1'b1, 1'b0);
            for (int k = 0; k < 7; k++) step(1'b0, 1'b0);
            check("t6_dout", dout, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check("t6_glitch", glitch_cnt, (g < 3) ? g : 3);
`endif
        end

        // Random bursts with occasional reset
        for (int b = 0; b < 120; b++) begin
            d    = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 7);
            if ($urandom_range(0, 40) == 0) step(d, 1'b1);
            for (int k = 0; k < hold; k++) step(d, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
